mshr_issue_engine: RTL and testbench
====================================

Name: mshr_issue_engine

Overview:
- Initiator/consumer on the MSHR read-next/delete interface. It sits between the cache MSHR and the memory bus.
- When the MSHR is non-empty it pulls the next entry with read_next and issues the entry as a memory request.
- For reads it waits for the response, returns fill data to the cache, then retires the entry via del.
- Handles one outstanding entry at a time.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 3, MSHR id width
RN_TIMEOUT, 15, max cycles to wait for rn_valid after read_next (1..255)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  when low, no new entry is fetched; an in-flight entry completes
empty  input  1  MSHR has no entries
read_next  output  1  one-cycle pulse requesting the next MSHR entry
rn_valid  input  1  MSHR entry fields valid (may stay high after capture)
rn_addr  input  ADDR_W  entry address
rn_data  input  DATA_W  entry write data
rn_rw  input  1  1 = write entry
rn_dirty  input  1  1 = dirty writeback entry
rn_mshr_id  input  ID_W  entry id
del  output  1  one-cycle pulse retiring an entry
del_addr  output  ADDR_W  address of the retired entry
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = memory write
mem_addr  output  ADDR_W  request address
mem_wdata  output  DATA_W  request write data
mem_ack  input  1  request accepted
mem_resp_valid  input  1  read data valid
mem_rdata  input  DATA_W  read data
fill_valid  output  1  one-cycle pulse, fill data to cache
fill_addr  output  ADDR_W  fill address
fill_data  output  DATA_W  fill data
fill_mshr_id  output  ID_W  fill id
busy  output  1  state != IDLE
rn_timeout  output  1  one-cycle pulse on fetch timeout

Behaviour:
- Reset (async, reset=0): state=IDLE; every output 0; captured registers and timeout counter 0. Reset asserted mid-operation abandons the entry: no del, no fill.
- IDLE: if enable && !empty, pulse read_next for one cycle and go to WAIT_RN. Otherwise stay in IDLE.
- WAIT_RN: counter starts at 0 on entry.
  - rn_valid is sampled only in this state.
  - On the first cycle rn_valid=1: capture addr, data, rw, dirty and id. Set we_q = rn_rw | rn_dirty. Go to ISSUE.
  - If the counter reaches RN_TIMEOUT with no rn_valid: pulse rn_timeout, return to IDLE, no del.
  - rn_valid arriving on the same cycle the counter hits the limit is captured, not timed out.
- ISSUE: mem_req=1, mem_we=we_q, mem_addr=addr_q, mem_wdata=data_q. All four are registered and stable until the ack cycle.
  - On mem_ack=1 the request is accepted. mem_req drops the next cycle.
  - If we_q=1, go to RETIRE; otherwise go to WAIT_RESP.
- WAIT_RESP: mem_req=0.
  - On mem_resp_valid=1, capture mem_rdata and go to RETIRE.
  - mem_resp_valid in any other state is ignored.
- RETIRE: one cycle.
  - del=1, del_addr=addr_q.
  - For reads only: fill_valid=1, fill_addr=addr_q, fill_data=captured rdata, fill_mshr_id=id_q.
  - Next state IDLE. A new read_next can issue at the earliest on the cycle after RETIRE.
- Minimum read latency, with ack and response each arriving after 1 cycle: read_next at T, rn_valid at T+1, mem_req T+2..T+3 (ack in T+3), response T+4, del/fill at T+5.
- enable=0 blocks only the IDLE->WAIT_RN transition.
- busy is combinational from state. All other outputs are registered.

Test Plan:
- Read entry: empty=0; rn_valid one cycle after read_next with addr=100, rw=0, dirty=0, id=2; mem_ack after 1 cycle; mem_resp_valid with rdata=0xDEADBEEF -> fill_valid pulse with fill_addr=100, fill_data=0xDEADBEEF, fill_mshr_id=2, and del with del_addr=100 in the same cycle, exactly once.
- Dirty writeback: entry addr=0x40, data=456, dirty=1 -> mem_we=1, mem_wdata=456 held until ack; del pulses the cycle after ack; no fill_valid; a mem_resp_valid afterwards is ignored.
- Backpressure: mem_ack held low 10 cycles -> mem_req, mem_addr and mem_we stay constant for all 10 cycles; exactly one del after ack plus response.
- Timeout with RN_TIMEOUT=4: rn_valid never asserted -> rn_timeout pulses once after 4 WAIT_RN cycles; state returns to IDLE; no mem_req; a new read_next follows if empty=0.
- Gating: empty=1 or enable=0 -> no read_next for 20 cycles; enable dropped during ISSUE -> entry still completes with del.
- Reset in WAIT_RESP -> all outputs 0 immediately (asynchronously); no del or fill; after release, normal fetch resumes.

Source files
------------

// File: rtl/mshr_issue_engine_if.sv
// -----------------------------------------------------------------------------
// mshr_issue_engine_if
// Purpose : bundles the three buses the MSHR issue engine talks on.
//           - MSHR read-next / delete : empty, read_next, rn_*, del, del_addr
//           - memory request / resp   : mem_req, mem_we, mem_addr, mem_wdata,
//                                       mem_ack, mem_resp_valid, mem_rdata
//           - cache fill return       : fill_valid, fill_addr, fill_data,
//                                       fill_mshr_id
// Modports: master = the issue engine, slave = MSHR / memory / cache side.
// -----------------------------------------------------------------------------
interface mshr_issue_engine_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 3
);
   // MSHR read-next / delete
   logic              empty;
   logic              read_next;
   logic              rn_valid;
   logic [ADDR_W-1:0] rn_addr;
   logic [DATA_W-1:0] rn_data;
   logic              rn_rw;
   logic              rn_dirty;
   logic [ID_W-1:0]   rn_mshr_id;
   logic              del;
   logic [ADDR_W-1:0] del_addr;
   // memory bus
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_rdata;
   // cache fill
   logic              fill_valid;
   logic [ADDR_W-1:0] fill_addr;
   logic [DATA_W-1:0] fill_data;
   logic [ID_W-1:0]   fill_mshr_id;

   modport master (
      input  empty, rn_valid, rn_addr, rn_data, rn_rw, rn_dirty, rn_mshr_id,
      input  mem_ack, mem_resp_valid, mem_rdata,
      output read_next, del, del_addr,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output fill_valid, fill_addr, fill_data, fill_mshr_id
   );

   modport slave (
      output empty, rn_valid, rn_addr, rn_data, rn_rw, rn_dirty, rn_mshr_id,
      output mem_ack, mem_resp_valid, mem_rdata,
      input  read_next, del, del_addr,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  fill_valid, fill_addr, fill_data, fill_mshr_id
   );
endinterface

// File: rtl/mshr_issue_engine.sv
// -----------------------------------------------------------------------------
// mshr_issue_engine
// Purpose : pulls entries out of the cache MSHR one at a time, issues each as
//           a memory request, returns read data to the cache as a fill and
//           retires the entry with a delete pulse.
// Ports   :
//   clk        - clock, everything on the rising edge
//   reset      - asynchronous, active-low
//   enable     - gates fetching of new entries (in-flight entry still finishes)
//   bus        - MSHR / memory / fill buses (mshr_issue_engine_if.master)
//   busy       - engine is not idle (combinational from state)
//   rn_timeout - one-cycle pulse when the MSHR fails to present an entry
// -----------------------------------------------------------------------------
module mshr_issue_engine #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 3,
   parameter int RN_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   mshr_issue_engine_if.master bus,
   output logic                busy,
   output logic                rn_timeout
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_RN   = 3'd1,
      ISSUE     = 3'd2,
      WAIT_RESP = 3'd3,
      RETIRE    = 3'd4
   } state_t;

   localparam logic [7:0] RN_LIMIT = 8'(RN_TIMEOUT);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              read_next_q, read_next_d;
   logic              rn_timeout_q, rn_timeout_d;
   logic              mem_req_q, mem_req_d;
   logic              del_q, del_d;
   logic [ADDR_W-1:0] del_addr_q, del_addr_d;
   logic              fill_valid_q, fill_valid_d;
   logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
   logic [DATA_W-1:0] fill_data_q, fill_data_d;
   logic [ID_W-1:0]   fill_id_q, fill_id_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         id_q         <= '0;
         read_next_q  <= 1'b0;
         rn_timeout_q <= 1'b0;
         mem_req_q    <= 1'b0;
         del_q        <= 1'b0;
         del_addr_q   <= '0;
         fill_valid_q <= 1'b0;
         fill_addr_q  <= '0;
         fill_data_q  <= '0;
         fill_id_q    <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         id_q         <= id_d;
         read_next_q  <= read_next_d;
         rn_timeout_q <= rn_timeout_d;
         mem_req_q    <= mem_req_d;
         del_q        <= del_d;
         del_addr_q   <= del_addr_d;
         fill_valid_q <= fill_valid_d;
         fill_addr_q  <= fill_addr_d;
         fill_data_q  <= fill_data_d;
         fill_id_q    <= fill_id_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      data_d       = data_q;
      we_d         = we_q;
      id_d         = id_q;
      mem_req_d    = mem_req_q;
      del_addr_d   = del_addr_q;
      fill_addr_d  = fill_addr_q;
      fill_data_d  = fill_data_q;
      fill_id_d    = fill_id_q;
      // pulse outputs default low so they last exactly one cycle
      read_next_d  = 1'b0;
      rn_timeout_d = 1'b0;
      del_d        = 1'b0;
      fill_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (enable && !bus.empty) begin
               read_next_d = 1'b1;
               state_d     = WAIT_RN;
            end
         end

         WAIT_RN: begin
            // rn_valid wins over the limit when both land in the same cycle
            if (bus.rn_valid) begin
               addr_d    = bus.rn_addr;
               data_d    = bus.rn_data;
               we_d      = bus.rn_rw | bus.rn_dirty;
               id_d      = bus.rn_mshr_id;
               mem_req_d = 1'b1;
               cnt_d     = '0;
               state_d   = ISSUE;
            end else if (cnt_q == RN_LIMIT - 8'd1) begin
               // this was the last allowed wait cycle
               rn_timeout_d = 1'b1;
               cnt_d        = '0;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ISSUE: begin
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               if (we_q) begin
                  // writes and writebacks have no response phase
                  del_d      = 1'b1;
                  del_addr_d = addr_q;
                  state_d    = RETIRE;
               end else begin
                  state_d = WAIT_RESP;
               end
            end
         end

         WAIT_RESP: begin
            if (bus.mem_resp_valid) begin
               del_d        = 1'b1;
               del_addr_d   = addr_q;
               fill_valid_d = 1'b1;
               fill_addr_d  = addr_q;
               fill_data_d  = bus.mem_rdata;
               fill_id_d    = id_q;
               state_d      = RETIRE;
            end
         end

         RETIRE: begin
            // del/fill are visible during this state; nothing else to do
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy             = (state_q != IDLE);
   assign rn_timeout       = rn_timeout_q;
   assign bus.read_next    = read_next_q;
   assign bus.del          = del_q;
   assign bus.del_addr     = del_addr_q;
   assign bus.mem_req      = mem_req_q;
   assign bus.mem_we       = we_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = data_q;
   assign bus.fill_valid   = fill_valid_q;
   assign bus.fill_addr    = fill_addr_q;
   assign bus.fill_data    = fill_data_q;
   assign bus.fill_mshr_id = fill_id_q;

endmodule

// File: tb/tb_mshr_issue_engine.sv
module tb_mshr_issue_engine;

   localparam int RN_T = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b1;
   logic busy;
   logic rn_timeout;

   int vectors = 0;
   int miscompares = 0;

   // pulse/cycle tallies, sampled at the rising edge
   int del_cnt = 0;
   int fill_cnt = 0;
   int to_cnt = 0;
   int rn_cnt = 0;
   int req_cnt = 0;

   mshr_issue_engine_if #(.ADDR_W(32), .DATA_W(32), .ID_W(3)) bus_if ();

   mshr_issue_engine #(
      .ADDR_W(32), .DATA_W(32), .ID_W(3), .RN_TIMEOUT(RN_T)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .bus(bus_if),
      .busy(busy),
      .rn_timeout(rn_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus_if.del === 1'b1)        del_cnt  <= del_cnt + 1;
      if (bus_if.fill_valid === 1'b1) fill_cnt <= fill_cnt + 1;
      if (rn_timeout === 1'b1)        to_cnt   <= to_cnt + 1;
      if (bus_if.read_next === 1'b1)  rn_cnt   <= rn_cnt + 1;
      if (bus_if.mem_req === 1'b1)    req_cnt  <= req_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_read_next"}, 64'(bus_if.read_next), 0);
      chk({tag, "_del"}, 64'(bus_if.del), 0);
      chk({tag, "_del_addr"}, 64'(bus_if.del_addr), 0);
      chk({tag, "_mem_req"}, 64'(bus_if.mem_req), 0);
      chk({tag, "_mem_we"}, 64'(bus_if.mem_we), 0);
      chk({tag, "_mem_addr"}, 64'(bus_if.mem_addr), 0);
      chk({tag, "_mem_wdata"}, 64'(bus_if.mem_wdata), 0);
      chk({tag, "_fill_valid"}, 64'(bus_if.fill_valid), 0);
      chk({tag, "_fill_addr"}, 64'(bus_if.fill_addr), 0);
      chk({tag, "_fill_data"}, 64'(bus_if.fill_data), 0);
      chk({tag, "_fill_id"}, 64'(bus_if.fill_mshr_id), 0);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_rn_timeout"}, 64'(rn_timeout), 0);
   endtask

   // junk on the entry fields whenever rn_valid is low
   task automatic scramble_rn();
      bus_if.rn_valid   = 1'b0;
      bus_if.rn_addr    = $urandom;
      bus_if.rn_data    = $urandom;
      bus_if.rn_rw      = 1'($urandom);
      bus_if.rn_dirty   = 1'($urandom);
      bus_if.rn_mshr_id = 3'($urandom);
   endtask

   task automatic wait_rn(output bit ok);
      int n = 0;
      while (bus_if.read_next !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      ok = (bus_if.read_next === 1'b1);
      chk("read_next_seen", 64'(ok), 1);
   endtask

   // One complete MSHR entry. rn_dly counts cycles after the read_next cycle
   // before rn_valid is shown; rn_dly >= RN_T means the MSHR never answers.
   task automatic run_entry(input logic [31:0] addr, input logic [31:0] data,
                            input bit rw, input bit dirty, input logic [2:0] id,
                            input int rn_dly, input int ack_dly, input int resp_dly,
                            input logic [31:0] rdata, input bit drop_en);
      bit ok;
      bit we;
      int del0, fill0, to0, req0;
      we    = rw | dirty;
      del0  = del_cnt;
      fill0 = fill_cnt;
      to0   = to_cnt;
      req0  = req_cnt;
      bus_if.empty = 1'b0;
      wait_rn(ok);
      if (!ok) return;
      bus_if.empty = 1'b1;

      if (rn_dly >= RN_T) begin
         repeat (RN_T) @(negedge clk);
         chk("rn_timeout_pulse", 64'(rn_timeout), 1);
         chk("busy_after_timeout", 64'(busy), 0);
         @(negedge clk);
         chk("rn_timeout_low_after", 64'(rn_timeout), 0);
         chk("timeout_count", 64'(to_cnt), 64'(to0 + 1));
         chk("timeout_no_req", 64'(req_cnt), 64'(req0));
         chk("timeout_no_del", 64'(del_cnt), 64'(del0));
         $display("entry addr=%08h rn_dly=%0d -> timeout", addr, rn_dly);
         return;
      end

      repeat (rn_dly) @(negedge clk);
      bus_if.rn_valid   = 1'b1;
      bus_if.rn_addr    = addr;
      bus_if.rn_data    = data;
      bus_if.rn_rw      = rw;
      bus_if.rn_dirty   = dirty;
      bus_if.rn_mshr_id = id;
      @(negedge clk);
      scramble_rn();
      chk("mem_req", 64'(bus_if.mem_req), 1);
      chk("mem_addr", 64'(bus_if.mem_addr), 64'(addr));
      chk("mem_we", 64'(bus_if.mem_we), 64'(we));
      chk("mem_wdata", 64'(bus_if.mem_wdata), 64'(data));
      if (drop_en) enable = 1'b0;
      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         chk("req_held", 64'(bus_if.mem_req), 1);
         chk("addr_held", 64'(bus_if.mem_addr), 64'(addr));
         chk("we_held", 64'(bus_if.mem_we), 64'(we));
         chk("wdata_held", 64'(bus_if.mem_wdata), 64'(data));
      end
      bus_if.mem_ack = 1'b1;
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      chk("req_drop", 64'(bus_if.mem_req), 0);

      if (we) begin
         chk("wr_del", 64'(bus_if.del), 1);
         chk("wr_del_addr", 64'(bus_if.del_addr), 64'(addr));
         chk("wr_no_fill", 64'(bus_if.fill_valid), 0);
         // a stray response after a write must be ignored
         bus_if.mem_resp_valid = 1'b1;
         bus_if.mem_rdata      = $urandom;
         @(negedge clk);
         bus_if.mem_resp_valid = 1'b0;
      end else begin
         chk("rd_no_early_del", 64'(bus_if.del), 0);
         repeat (resp_dly) @(negedge clk);
         bus_if.mem_resp_valid = 1'b1;
         bus_if.mem_rdata      = rdata;
         @(negedge clk);
         bus_if.mem_resp_valid = 1'b0;
         bus_if.mem_rdata      = $urandom;
         chk("rd_del", 64'(bus_if.del), 1);
         chk("rd_del_addr", 64'(bus_if.del_addr), 64'(addr));
         chk("fill_valid", 64'(bus_if.fill_valid), 1);
         chk("fill_addr", 64'(bus_if.fill_addr), 64'(addr));
         chk("fill_data", 64'(bus_if.fill_data), 64'(rdata));
         chk("fill_id", 64'(bus_if.fill_mshr_id), 64'(id));
      end
      @(negedge clk);
      @(negedge clk);
      chk("del_once", 64'(del_cnt), 64'(del0 + 1));
      chk("fill_count", 64'(fill_cnt), 64'(fill0 + (we ? 0 : 1)));
      chk("idle_after", 64'(busy), 0);
      enable = 1'b1;
      $display("entry addr=%08h we=%0d id=%0d rn_dly=%0d ack_dly=%0d resp_dly=%0d -> retired",
               addr, we, id, rn_dly, ack_dly, resp_dly);
   endtask

   initial begin
      bit ok;
      int rn0, del0, fill0;
      bus_if.empty          = 1'b1;
      bus_if.mem_ack        = 1'b0;
      bus_if.mem_resp_valid = 1'b0;
      bus_if.mem_rdata      = '0;
      scramble_rn();

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);
      chk_all_zero("post_reset");
      $display("reset released, outputs idle");

      // plain read, minimum-latency handshakes
      run_entry(32'd100, 32'h0, 1'b0, 1'b0, 3'd2, 1, 1, 0, 32'hDEADBEEF, 1'b0);
      // dirty writeback
      run_entry(32'h40, 32'd456, 1'b0, 1'b1, 3'd5, 1, 2, 0, 32'h0, 1'b0);
      // plain write
      run_entry(32'h80, 32'h1111_2222, 1'b1, 1'b0, 3'd1, 0, 0, 0, 32'h0, 1'b0);
      // backpressure: ack held off for 10 cycles
      run_entry(32'h1234, 32'h0, 1'b0, 1'b0, 3'd7, 1, 10, 2, 32'hCAFE_F00D, 1'b0);
      // rn_valid on the very last allowed cycle is still captured
      run_entry(32'h200, 32'h55, 1'b0, 1'b0, 3'd3, RN_T - 1, 0, 1, 32'h0BAD_C0DE, 1'b0);

      // timeout with empty held low, then the follow-on fetch
      bus_if.empty = 1'b0;
      rn0 = rn_cnt;
      wait_rn(ok);
      repeat (RN_T) @(negedge clk);
      chk("to_pulse", 64'(rn_timeout), 1);
      chk("to_idle", 64'(busy), 0);
      chk("to_no_req", 64'(bus_if.mem_req), 0);
      @(negedge clk);
      chk("to_refetch", 64'(bus_if.read_next), 1);
      $display("timeout then refetch, read_next pulses=%0d", rn_cnt - rn0);
      run_entry(32'h300, 32'h0, 1'b0, 1'b0, 3'd4, 0, 1, 1, 32'h1357_9BDF, 1'b0);

      // gating: empty high, then enable low
      bus_if.empty = 1'b1;
      rn0 = rn_cnt;
      repeat (20) @(negedge clk);
      chk("gate_empty", 64'(rn_cnt), 64'(rn0));
      enable = 1'b0;
      bus_if.empty = 1'b0;
      repeat (20) @(negedge clk);
      chk("gate_enable", 64'(rn_cnt), 64'(rn0));
      chk("gate_idle", 64'(busy), 0);
      bus_if.empty = 1'b1;
      enable = 1'b1;
      $display("gating: no read_next over 40 cycles");

      // enable dropped while the request is outstanding
      run_entry(32'h400, 32'h0, 1'b0, 1'b0, 3'd6, 1, 3, 1, 32'h2468_ACE0, 1'b1);
      run_entry(32'h404, 32'h77, 1'b1, 1'b1, 3'd0, 1, 3, 0, 32'h0, 1'b1);

      // asynchronous reset while waiting for the response
      bus_if.empty = 1'b0;
      wait_rn(ok);
      bus_if.empty      = 1'b1;
      bus_if.rn_valid   = 1'b1;
      bus_if.rn_addr    = 32'h777;
      bus_if.rn_data    = 32'h0;
      bus_if.rn_rw      = 1'b0;
      bus_if.rn_dirty   = 1'b0;
      bus_if.rn_mshr_id = 3'd1;
      @(negedge clk);
      scramble_rn();
      bus_if.mem_ack = 1'b1;
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      chk("rst_in_wait_resp", 64'(busy), 1);
      del0  = del_cnt;
      fill0 = fill_cnt;
      #2 reset = 1'b0;
      #1 chk_all_zero("async_reset");
      bus_if.mem_resp_valid = 1'b1;
      bus_if.mem_rdata      = 32'h9999_9999;
      repeat (3) @(negedge clk);
      bus_if.mem_resp_valid = 1'b0;
      chk("rst_no_del", 64'(del_cnt), 64'(del0));
      chk("rst_no_fill", 64'(fill_cnt), 64'(fill0));
      reset = 1'b1;
      @(negedge clk);
      $display("reset during WAIT_RESP abandoned entry");
      run_entry(32'h800, 32'h0, 1'b0, 1'b0, 3'd2, 1, 1, 0, 32'hA5A5_5A5A, 1'b0);

      // randomized entries against the transaction-level expectations
      for (int n = 0; n < 40; n++) begin
         run_entry($urandom, $urandom, 1'($urandom), 1'($urandom), 3'($urandom),
                   int'($urandom_range(0, RN_T + 1)), int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
